// File: rtl/s526_bist_pkg.sv
// Shared types and constants for the s526 BIST driver/analyser.
package s526_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } bist_state_t;

    localparam int unsigned SIG_W  = 16;
    localparam int unsigned PAT_W  = 3;
    localparam int unsigned RESP_W = 6;

    // Fibonacci taps 16,14,13,11 as a bit mask over lfsr[15:0]
    localparam logic [SIG_W-1:0] LFSR_TAPS = 16'hB400;
    localparam logic [SIG_W-1:0] MISR_POLY = 16'h1021;

    // dut_out bit positions of the core's primary outputs
    localparam int unsigned IDX_G147 = 0;
    localparam int unsigned IDX_G148 = 1;
    localparam int unsigned IDX_G198 = 2;
    localparam int unsigned IDX_G199 = 3;
    localparam int unsigned IDX_G213 = 4;
    localparam int unsigned IDX_G214 = 5;

    function automatic logic [SIG_W-1:0] lfsr_step(input logic [SIG_W-1:0] v);
        return {v[SIG_W-2:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/bist_misr.sv
// 16-bit multiple-input signature register with seed load and 6-bit parallel input.
module bist_misr
    import s526_bist_pkg::*;
#(
    parameter logic [15:0] SEED = 16'h0000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                en,
    input  logic [RESP_W-1:0]   din,
    output logic [SIG_W-1:0]    sig,
    output logic [SIG_W-1:0]    sig_next_c
);

    assign sig_next_c = {sig[SIG_W-2:0], 1'b0}
                      ^ (sig[SIG_W-1] ? MISR_POLY : SIG_W'(0))
                      ^ SIG_W'(din);

    // Seed load wins over capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= SEED;
        end else if (load) begin
            sig <= SEED;
        end else if (en) begin
            sig <= sig_next_c;
        end
    end

endmodule

// File: rtl/s526_bist_ctrl.sv
// BIST controller for the s526 core: LFSR pattern source after a G0 flush,
// MISR response compaction and golden-signature compare.
module s526_bist_ctrl
    import s526_bist_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned INIT_CYCLES = 4,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter logic [15:0] MISR_SEED   = 16'h0000
) (
    input  logic               CK,
    input  logic               RN,
    input  logic               start,
    input  logic [CNT_W-1:0]   pat_count,
    input  logic [15:0]        golden,
    output logic [2:0]         dut_in,
    input  logic [5:0]         dut_out,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [15:0]        signature
);

    localparam int unsigned INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);

    bist_state_t        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [INIT_W-1:0]  init_q, init_d;
    logic [SIG_W-1:0]   lfsr_q, lfsr_d;
    logic [SIG_W-1:0]   gold_q, gold_d;
    logic               capture_en_q;
    logic               pass_d;
    logic [PAT_W-1:0]   dut_in_d;
    logic               busy_d, done_d;
    logic               misr_load;
    logic [RESP_W-1:0]  misr_din;
    logic [SIG_W-1:0]   misr_sig, misr_step_c, misr_nxt_c;

    assign misr_din = {dut_out[IDX_G214], dut_out[IDX_G213], dut_out[IDX_G199],
                       dut_out[IDX_G198], dut_out[IDX_G148], dut_out[IDX_G147]};

    bist_misr #(
        .SEED (MISR_SEED)
    ) u_misr (
        .clk        (CK),
        .rst_n      (RN),
        .load       (misr_load),
        .en         (capture_en_q),
        .din        (misr_din),
        .sig        (misr_sig),
        .sig_next_c (misr_step_c)
    );

    // Value the MISR will hold after this cycle, used for the final compare
    assign misr_nxt_c = capture_en_q ? misr_step_c : misr_sig;

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            init_q       <= '0;
            lfsr_q       <= LFSR_SEED;
            gold_q       <= '0;
            capture_en_q <= 1'b0;
            dut_in       <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            init_q       <= init_d;
            lfsr_q       <= lfsr_d;
            gold_q       <= gold_d;
            capture_en_q <= (state_q == ST_RUN);
            dut_in       <= dut_in_d;
            busy         <= busy_d;
            done         <= done_d;
            pass         <= pass_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        init_d    = init_q;
        lfsr_d    = lfsr_q;
        gold_d    = gold_q;
        pass_d    = pass;
        misr_load = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_INIT;
                    cnt_d     = pat_count;
                    gold_d    = golden;
                    init_d    = '0;
                    lfsr_d    = LFSR_SEED;
                    pass_d    = 1'b0;
                    misr_load = 1'b1;
                end
            end
            ST_INIT: begin
                init_d = init_q + INIT_W'(1);
                if (init_q == INIT_LAST) begin
                    state_d = (cnt_q == '0) ? ST_DRAIN : ST_RUN;
                end
            end
            ST_RUN: begin
                // cnt_q holds the patterns still to apply, including this one
                lfsr_d = lfsr_step(lfsr_q);
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
                pass_d  = (misr_nxt_c == gold_q);
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered outputs decode the state being entered
        dut_in_d = '0;
        case (state_d)
            ST_INIT: dut_in_d = 3'b001;
            ST_RUN:  dut_in_d = lfsr_d[PAT_W-1:0];
            default: dut_in_d = '0;
        endcase
        busy_d = (state_d == ST_INIT) || (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    assign signature = misr_sig;

endmodule

// File: tb/tb_s526_bist_ctrl.sv
// Directed bench for s526_bist_ctrl with a small stand-in core that flushes under G0.
module tb_s526_bist_ctrl;

    logic        CK = 1'b0;
    logic        RN = 1'b1;
    logic        start;
    logic [15:0] pat_count;
    logic [15:0] golden;
    logic [2:0]  dut_in;
    logic [5:0]  dut_out;
    logic        busy, done, pass;
    logic [15:0] signature;

    int n_tests = 0;
    int n_fail  = 0;

    logic [2:0] seen [64];
    int         busy_cyc;
    logic [2:0] exp_pat [5];
    logic [15:0] model_sig;

    always #5 CK = ~CK;

    s526_bist_ctrl dut (
        .CK        (CK),
        .RN        (RN),
        .start     (start),
        .pat_count (pat_count),
        .golden    (golden),
        .dut_in    (dut_in),
        .dut_out   (dut_out),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .signature (signature)
    );

    // Stand-in core: registered outputs; three cycles of G0=1 fully determine its state
    function automatic logic [5:0] core_step(input logic [5:0] s, input logic [2:0] i);
        return {s[3:0], i[2:1]} ^ {5'b0, i[0]};
    endfunction

    logic [5:0] core_q;
    always @(posedge CK) core_q <= core_step(core_q, dut_in);
    assign dut_out = core_q;

    function automatic logic [15:0] misr_ref(input logic [15:0] m, input logic [5:0] d);
        logic [15:0] r;
        r = m << 1;
        if (m[15]) r = r ^ 16'h1021;
        return r ^ {10'b0, d};
    endfunction

    function automatic logic [15:0] expected_sig(input int n);
        logic [5:0]  s;
        logic [15:0] m;
        s = 6'h0;
        m = 16'h0000;
        for (int i = 0; i < 4; i++) s = core_step(s, 3'b001);
        for (int k = 0; k < n; k++) begin
            s = core_step(s, exp_pat[k]);
            m = misr_ref(m, s);
        end
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after busy falls (or the bound expires)
    task automatic do_run(input logic [15:0] cnt, input logic [15:0] gold, input int poke_at);
        start     = 1'b1;
        pat_count = cnt;
        golden    = gold;
        @(negedge CK);
        start = 1'b0;
        check("run_start_done_low", 32'(done), 32'(1'b0));
        check("run_start_busy", 32'(busy), 32'(1'b1));
        busy_cyc = 0;
        while (busy && busy_cyc < 70000) begin
            if (busy_cyc < 64) seen[busy_cyc] = dut_in;
            start = (busy_cyc == poke_at);
            busy_cyc++;
            @(negedge CK);
        end
        start = 1'b0;
        check("run_done_level", 32'(done), 32'(1'b1));
        check("run_done_dut_in", 32'(dut_in), 32'(3'b000));
    endtask

    task automatic check_nominal_patterns();
        for (int i = 0; i < 4; i++) check("init_pattern", 32'(seen[i]), 32'(3'b001));
        for (int k = 0; k < 5; k++) check("run_pattern", 32'(seen[4+k]), 32'(exp_pat[k]));
        check("drain_pattern", 32'(seen[9]), 32'(3'b000));
    endtask

    initial begin
        // LFSR from ACE1: ACE1, 59C3, B387, 670F, CE1E -> low 3 bits
        exp_pat[0] = 3'b001;
        exp_pat[1] = 3'b011;
        exp_pat[2] = 3'b111;
        exp_pat[3] = 3'b111;
        exp_pat[4] = 3'b110;
        model_sig  = expected_sig(5);

        start     = 1'b0;
        pat_count = 16'd0;
        golden    = 16'h0000;

        // Asynchronous reset mid-cycle, checked before any clock edge
        #2 RN = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'(1'b0));
        check("rst_done", 32'(done), 32'(1'b0));
        check("rst_pass", 32'(pass), 32'(1'b0));
        check("rst_sig", 32'(signature), 32'h0000);
        check("rst_dut_in", 32'(dut_in), 32'(3'b000));
        @(negedge CK);
        RN = 1'b1;
        repeat (2) @(negedge CK);
        check("idle_dut_in", 32'(dut_in), 32'(3'b000));
        check("idle_busy", 32'(busy), 32'(1'b0));

        // Reset in RUN after three patterns applied
        start     = 1'b1;
        pat_count = 16'd5;
        golden    = model_sig;
        @(negedge CK);
        start = 1'b0;
        repeat (7) @(negedge CK);
        check("midrun_pattern", 32'(dut_in), 32'(exp_pat[3]));
        RN = 1'b0;
        #1;
        check("midrun_rst_busy", 32'(busy), 32'(1'b0));
        check("midrun_rst_sig", 32'(signature), 32'h0000);
        check("midrun_rst_dut_in", 32'(dut_in), 32'(3'b000));
        check("midrun_rst_done", 32'(done), 32'(1'b0));
        #1 RN = 1'b1;
        @(negedge CK);
        check("midrun_idle_busy", 32'(busy), 32'(1'b0));

        // Nominal run
        do_run(16'd5, model_sig, -1);
        check("nom_busy_cycles", 32'(busy_cyc), 32'd10);
        check_nominal_patterns();
        check("nom_sig", 32'(signature), 32'(model_sig));
        check("nom_pass", 32'(pass), 32'(1'b1));
        repeat (3) @(negedge CK);
        check("nom_done_hold", 32'(done), 32'(1'b1));
        check("nom_sig_hold", 32'(signature), 32'(model_sig));

        // Golden mismatch, started straight from DONE
        do_run(16'd5, model_sig ^ 16'h0001, -1);
        check("mis_busy_cycles", 32'(busy_cyc), 32'd10);
        check("mis_sig", 32'(signature), 32'(model_sig));
        check("mis_pass", 32'(pass), 32'(1'b0));

        // start pulsed during RUN is ignored
        do_run(16'd5, model_sig, 6);
        check("poke_busy_cycles", 32'(busy_cyc), 32'd10);
        check_nominal_patterns();
        check("poke_sig", 32'(signature), 32'(model_sig));
        check("poke_pass", 32'(pass), 32'(1'b1));

        // Zero patterns
        do_run(16'd0, 16'h0000, -1);
        check("zero_busy_cycles", 32'(busy_cyc), 32'd5);
        for (int i = 0; i < 4; i++) check("zero_init_pattern", 32'(seen[i]), 32'(3'b001));
        check("zero_drain_pattern", 32'(seen[4]), 32'(3'b000));
        check("zero_sig", 32'(signature), 32'h0000);
        check("zero_pass", 32'(pass), 32'(1'b1));

        // Full-scale count must not wrap
        do_run(16'hFFFF, 16'h0000, -1);
        check("max_busy_cycles", 32'(busy_cyc), 32'd65540);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/s526_bist_ctrl.md
Name: s526_bist_ctrl

Overview:
- On-chip BIST driver/analyser for the s526 sequential benchmark core, acting as the opposite end of its port set.
- Generates the core's primary inputs G0/G1/G2 from an LFSR, after a G0-forced initialisation flush.
- Compacts the core's six primary outputs into a MISR signature and compares it against a golden value.
- Sits between the test-access logic (start/result handshake) and the core under test, for oracle-query and locking-evaluation runs.

Parameters:
- CNT_W, 16, width of pattern counter and pat_count.
- INIT_CYCLES, 4, cycles G0 is held 1 before patterns start (≥1).
- LFSR_SEED, 16'hACE1, LFSR load value at start (nonzero).
- MISR_SEED, 16'h0000, MISR load value at start.

Ports:
- CK  in  1  clock, rising-edge.
- RN  in  1  asynchronous active-low reset.
- start  in  1  run request, sampled in IDLE or DONE.
- pat_count  in  CNT_W  number of patterns; sampled with start.
- golden  in  16  expected signature; sampled with start.
- dut_in  out  3  to core: [0]=G0, [1]=G1, [2]=G2.
- dut_out  in  6  from core: [0]=G147, [1]=G148, [2]=G198, [3]=G199, [4]=G213, [5]=G214.
- busy  out  1  high in INIT/RUN/DRAIN.
- done  out  1  high in DONE state (level).
- pass  out  1  valid while done; signature==golden.
- signature  out  16  current MISR value.

Behaviour:
- Reset (RN low, asynchronous): state=IDLE; dut_in=000; busy=0; done=0; pass=0; signature=MISR_SEED; lfsr=LFSR_SEED; counters=0; capture_en=0.
- All outputs are registered.
- FSM states: IDLE, INIT, RUN, DRAIN, DONE.
- IDLE/DONE with start=1:
  - latch pat_count and golden; lfsr←LFSR_SEED; MISR←MISR_SEED; pass←0; done←0.
  - go to INIT.
  - start is ignored while busy.
- INIT: dut_in=001 (G0=1 flushes core state) for exactly INIT_CYCLES cycles; MISR frozen.
  - If latched count==0, go to DRAIN.
  - Otherwise go to RUN.
- RUN: dut_in=lfsr[2:0] each cycle; LFSR advances every RUN cycle.
  - LFSR: Fibonacci, 16-bit, taps 16,14,13,11; shift left, new bit into [0].
  - Exactly count cycles, then DRAIN.
- Capture latency:
  - s526 outputs are flop outputs, so the response to a pattern applied in cycle t is valid in cycle t+1.
  - capture_en is RUN delayed by one cycle; the MISR updates only when capture_en=1.
  - This gives exactly count MISR updates, the last one in DRAIN.
  - INIT-cycle responses are never captured.
- MISR update: next = {m[14:0],0} XOR (m[15] ? 16'h1021 : 0) XOR {10'b0,dut_out}.
- DRAIN: one cycle; dut_in=000. Next state DONE; pass←(MISR_next==golden).
- DONE: done=1, busy=0, dut_in=000; signature and pass hold until the next start.
- busy is high for exactly INIT_CYCLES+count+1 cycles.
- Count width: pat_count=2^CNT_W−1 must run fully; no wrap.
- Mid-run reset: immediate return to reset values; no partial result is retained.

Decomposition:
- Shared package s526_bist_pkg:
  - state enum;
  - LFSR tap mask;
  - MISR polynomial constant 16'h1021;
  - dut_out bit-index constants.
- Sub-module bist_misr: 16-bit MISR with enable, seed load and 6-bit parallel input.
- The LFSR stays inline.

Test Plan:
- Reset then idle: RN pulse low mid-cycle → all outputs at reset values immediately, without waiting for a clock edge. dut_in=000 thereafter with start=0.
- Nominal run: pat_count=5, INIT_CYCLES=4.
  - busy high exactly 10 cycles.
  - dut_in=001 for 4 cycles, then lfsr[2:0] sequence from seed ACE1 (first = 3'b001).
  - Then done=1 with signature equal to the reference model over s526; golden=model → pass=1.
- Mismatch: same run with golden=model^16'h0001 → done=1, pass=0, signature unchanged from nominal.
- Zero count: pat_count=0 → busy 5 cycles, no RUN, signature=0000; golden=0000 → pass=1.
- Start handling: start asserted during RUN → ignored, run length unchanged. start in DONE → done drops next cycle and a new run begins with reseeded LFSR/MISR.
- Reset mid-run: RN low in RUN after 3 patterns → IDLE, signature=0000, dut_in=000. A subsequent start with pat_count=5 reproduces the nominal signature exactly.
